// File: rtl/bsg_axil_master_arbiter.sv
// Round-robin arbiter that shares one AXI4-Lite master port among several
// valid/ready clients. Only one transaction is in flight at a time. The
// granted client's response is returned on a shared data/err bus, and
// resp_v_o marks the owner with a one-hot bit.
module bsg_axil_master_arbiter #(
   parameter int num_clients_p = 2,
   parameter int addr_width_p  = 32,
   parameter int data_width_p  = 32
) (
   input  logic                                    aclk_i,
   input  logic                                    aresetn_i,

   input  logic [num_clients_p-1:0]                cmd_v_i,
   input  logic [num_clients_p-1:0]                cmd_w_i,
   input  logic [num_clients_p*addr_width_p-1:0]   cmd_addr_i,
   input  logic [num_clients_p*data_width_p-1:0]   cmd_data_i,
   input  logic [num_clients_p*data_width_p/8-1:0] cmd_strb_i,
   output logic [num_clients_p-1:0]                cmd_ready_and_o,

   output logic [num_clients_p-1:0]                resp_v_o,
   output logic [data_width_p-1:0]                 resp_data_o,
   output logic [1:0]                              resp_err_o,
   input  logic [num_clients_p-1:0]                resp_ready_and_i,

   output logic [addr_width_p-1:0]                 awaddr_o,
   output logic [2:0]                              awprot_o,
   output logic                                    awvalid_o,
   input  logic                                    awready_i,

   output logic [data_width_p-1:0]                 wdata_o,
   output logic [data_width_p/8-1:0]               wstrb_o,
   output logic                                    wvalid_o,
   input  logic                                    wready_i,

   input  logic [1:0]                              bresp_i,
   input  logic                                    bvalid_i,
   output logic                                    bready_o,

   output logic [addr_width_p-1:0]                 araddr_o,
   output logic [2:0]                              arprot_o,
   output logic                                    arvalid_o,
   input  logic                                    arready_i,

   input  logic [data_width_p-1:0]                 rdata_i,
   input  logic [1:0]                              rresp_i,
   input  logic                                    rvalid_i,
   output logic                                    rready_o
);

   localparam int strb_width_lp = data_width_p / 8;
   localparam int id_width_lp   = (num_clients_p > 1) ? $clog2(num_clients_p) : 1;
   localparam int cand_width_lp = id_width_lp + 1;

   typedef enum logic [2:0] {IDLE, WRITE, BRESP, READ, RDATA, RESP} state_e;

   state_e                     state_q;
   logic [id_width_lp-1:0]     rr_q;
   logic [id_width_lp-1:0]     owner_q;
   logic [addr_width_p-1:0]    addr_q;
   logic [data_width_p-1:0]    data_q;
   logic [strb_width_lp-1:0]   strb_q;
   logic                       awvalid_q, wvalid_q, aw_done_q, w_done_q;
   logic                       bready_q, arvalid_q, rready_q;
   logic [num_clients_p-1:0]   resp_v_q;
   logic [data_width_p-1:0]    resp_data_q;
   logic [1:0]                 resp_err_q;

   // Per-client views of the packed command buses.
   logic [addr_width_p-1:0]  addr_a [num_clients_p];
   logic [data_width_p-1:0]  data_a [num_clients_p];
   logic [strb_width_lp-1:0] strb_a [num_clients_p];

   for (genvar i = 0; i < num_clients_p; i++) begin : g_unpack
      assign addr_a[i] = cmd_addr_i[i*addr_width_p +: addr_width_p];
      assign data_a[i] = cmd_data_i[i*data_width_p +: data_width_p];
      assign strb_a[i] = cmd_strb_i[i*strb_width_lp +: strb_width_lp];
   end

   logic                   grant_v;
   logic [id_width_lp-1:0] grant_id;
   logic [cand_width_lp-1:0] cand;

   // Pick the first requester at or after the rr pointer, wrapping around.
   always_comb begin
      // NOTE: every variable gets a default before the loop so that no path leaves it unassigned (which would infer a latch).
      grant_v  = 1'b0;
      grant_id = '0;
      cand     = '0;
      for (int i = 0; i < num_clients_p; i++) begin
         cand = {1'b0, rr_q} + cand_width_lp'(i);
         if (cand >= cand_width_lp'(num_clients_p))
            cand = cand - cand_width_lp'(num_clients_p);
         if (!grant_v && cmd_v_i[cand[id_width_lp-1:0]]) begin
            grant_v  = 1'b1;
            grant_id = cand[id_width_lp-1:0];
         end
      end
   end

   // The accept is combinational and only in IDLE. It is held low while reset is asserted.
   always_comb begin
      cmd_ready_and_o = '0;
      if (aresetn_i && state_q == IDLE && grant_v)
         cmd_ready_and_o[grant_id] = 1'b1;
   end

   logic [num_clients_p-1:0] owner_oh;
   logic                     aw_done_n, w_done_n;

   // Decode the owner to one-hot and merge each channel's handshake into its sticky done flag.
   always_comb begin
      owner_oh          = '0;
      owner_oh[owner_q] = 1'b1;
      aw_done_n         = aw_done_q | (awvalid_q & awready_i);
      w_done_n          = w_done_q  | (wvalid_q  & wready_i);
   end

   // Transaction FSM. All AXI and response outputs are registered here.
   always_ff @(posedge aclk_i or negedge aresetn_i) begin
      if (!aresetn_i) begin
         state_q     <= IDLE;
         rr_q        <= '0;
         owner_q     <= '0;
         addr_q      <= '0;
         data_q      <= '0;
         strb_q      <= '0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         resp_v_q    <= '0;
         resp_data_q <= '0;
         resp_err_q  <= '0;
      end else begin
         // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
         case (state_q)
            IDLE: if (grant_v) begin
               owner_q <= grant_id;
               addr_q  <= addr_a[grant_id];
               data_q  <= data_a[grant_id];
               strb_q  <= strb_a[grant_id];
               if (cmd_w_i[grant_id]) begin
                  awvalid_q <= 1'b1;
                  wvalid_q  <= 1'b1;
                  aw_done_q <= 1'b0;
                  w_done_q  <= 1'b0;
                  state_q   <= WRITE;
               end else begin
                  arvalid_q <= 1'b1;
                  state_q   <= READ;
               end
            end
            WRITE: begin
               if (awready_i) awvalid_q <= 1'b0;
               if (wready_i)  wvalid_q  <= 1'b0;
               aw_done_q <= aw_done_n;
               w_done_q  <= w_done_n;
               if (aw_done_n && w_done_n) begin
                  bready_q <= 1'b1;
                  state_q  <= BRESP;
               end
            end
            BRESP: if (bvalid_i) begin
               bready_q    <= 1'b0;
               resp_err_q  <= bresp_i;
               resp_data_q <= '0;
               resp_v_q    <= owner_oh;
               state_q     <= RESP;
            end
            READ: if (arready_i) begin
               arvalid_q <= 1'b0;
               rready_q  <= 1'b1;
               state_q   <= RDATA;
            end
            RDATA: if (rvalid_i) begin
               rready_q    <= 1'b0;
               resp_data_q <= rdata_i;
               resp_err_q  <= rresp_i;
               resp_v_q    <= owner_oh;
               state_q     <= RESP;
            end
            RESP: if (resp_ready_and_i[owner_q]) begin
               resp_v_q <= '0;
               rr_q     <= (owner_q == id_width_lp'(num_clients_p - 1)) ? '0 : owner_q + 1'b1;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign awaddr_o    = addr_q;
   assign araddr_o    = addr_q;
   assign awprot_o    = 3'b000;
   assign arprot_o    = 3'b000;
   assign awvalid_o   = awvalid_q;
   assign wdata_o     = data_q;
   assign wstrb_o     = strb_q;
   assign wvalid_o    = wvalid_q;
   assign bready_o    = bready_q;
   assign arvalid_o   = arvalid_q;
   assign rready_o    = rready_q;
   assign resp_v_o    = resp_v_q;
   assign resp_data_o = resp_data_q;
   assign resp_err_o  = resp_err_q;

endmodule
